// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO control blocks (write-side arbiter and a
// future read-side scheduler).
//   arb_state_t : arbiter FSM state encoding (ST_IDLE = 0, ST_BURST = 1)
//   cnt_width() : bit width needed to hold a count from 0 up to max inclusive
package fifo_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // Width of a counter that must reach the value max itself (not max-1).
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req    : request vector, one bit per requester
//   ptr    : index where the search starts (highest priority this round)
//   winner : first set request at or above ptr, wrapping past NUM_REQ-1
//   any    : at least one request is set (winner is 0 when clear)
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);

  int            idx;
  logic [IW-1:0] sel;

  // Walk the offsets from farthest to nearest so the requester closest to
  // ptr is the last one written and therefore wins.
  always_comb begin
    winner = '0;
    any    = |req;
    idx    = 0;
    sel    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = IW'(idx);
      if (req[sel]) winner = sel;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-granular round-robin arbiter for the write port of an async FIFO.
// NUM_REQ producers in the write clock domain share one FIFO write port; a
// winner keeps the port until its last beat is written.
//   wclk, wrst : write clock, synchronous active-high reset
//   req_valid  : per-requester beat valid
//   req_last   : per-requester last beat of packet
//   req_data   : flattened data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  : per-requester beat accept
//   full       : FIFO full flag (already synchronized to wclk)
//   w_en       : FIFO write enable
//   data_in    : FIFO write data
//   grant      : one-hot current owner, zero when idle (registered)
//   busy       : a packet is in progress (registered, state == BURST)
//   overrun    : sticky, a packet ran past MAX_BEATS beats (registered)
//
// Handshake: a beat from requester i transfers on a cycle where
// req_valid[i] && req_ready[i]; that is exactly the cycle w_en is high.
// ready never depends on the requester's own valid, only on ownership and
// full, and valid may be dropped at any time (the grant is simply held).
module fifo_write_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 64
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(MAX_BEATS);

  arb_state_t    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] beat_cnt;

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          in_burst;
  logic          owner_valid;
  logic          owner_last;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .winner (pick_idx),
    .any    (pick_any)
  );

  assign in_burst    = (state == ST_BURST);
  assign owner_valid = req_valid[owner];
  assign owner_last  = req_last[owner];

  // Only the owner can write, and never into a full FIFO.
  assign w_en = in_burst & owner_valid & ~full;

  // data_in is forced to zero outside a burst so the FIFO data bus is quiet
  // while idle and after reset.
  always_comb begin
    req_ready = '0;
    data_in   = '0;
    if (in_burst) begin
      req_ready[owner] = ~full;
      data_in          = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state    <= ST_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      overrun  <= 1'b0;
      grant    <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state <= ST_BURST;
            owner <= pick_idx;
            grant <= NUM_REQ'(1) << pick_idx;
            busy  <= 1'b1;
          end
        end
        ST_BURST: begin
          if (w_en) begin
            if (owner_last) begin
              state    <= ST_IDLE;
              grant    <= '0;
              busy     <= 1'b0;
              beat_cnt <= '0;
              // Next search starts just past the requester that was served.
              rr_ptr   <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
            end else if (beat_cnt == CW'(MAX_BEATS)) begin
              // Packet is longer than allowed: flag it, keep the grant and
              // hold the counter at its limit.
              overrun <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  // ---------------- clock / reset ----------------
  logic wclk = 1'b0;
  logic wrst = 1'b1;
  always #5 wclk = ~wclk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_ready;
  logic            full = 1'b0;
  logic            w_en;
  logic [DW-1:0]   data_in;
  logic [N-1:0]    grant;
  logic            busy;
  logic            overrun;

  fifo_write_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MAXB)
  ) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .w_en      (w_en),
    .data_in   (data_in),
    .grant     (grant),
    .busy      (busy),
    .overrun   (overrun)
  );

  // ---------------- bench state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [DW-1:0] bq_data[N][$];   // pending beats per producer
  bit            bq_last[N][$];
  logic [DW-1:0] exp_q[$];        // expected FIFO contents, in order
  int            gnt_log[$];
  logic [DW-1:0] wr_log[$];
  int            wr_cyc[$];
  int            n_writes = 0;
  bit            acc[N];
  int            acc_cnt[N];
  logic [N-1:0]  en = '0;
  bit            full_drv = 1'b0;

  // reference model state: packet owner (-1 idle), next search start, beats
  int            m_owner = -1;
  int            m_ptr   = 0;
  int            m_beats = 0;
  bit            m_ov    = 1'b0;
  logic [N-1:0]  m_eg;
  bit            m_ew;
  int            m_j;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge wclk) begin
    for (int i = 0; i < N; i++) acc[i] = 1'b0;
    if (wrst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_beats = 0;
      m_ov    = 1'b0;
      exp_q.delete();
    end else begin
      m_eg = '0;
      m_ew = 1'b0;
      if (m_owner >= 0) begin
        m_eg = N'(1 << m_owner);
        m_ew = req_valid[m_owner] && !full;
      end
      chk("grant", 32'(grant), 32'(m_eg));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("overrun", 32'(overrun), 32'(m_ov));
      chk("w_en", 32'(w_en), 32'(m_ew));
      chk("req_ready", 32'(req_ready), full ? 32'd0 : 32'(m_eg));
      if (m_owner < 0) chk("data_in_idle", 32'(data_in), 32'd0);
      for (int i = 0; i < N; i++) acc[i] = req_valid[i] & req_ready[i];
      if (m_ew) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL data_in at cycle %0d: got 0x%0h, expected nothing queued", cyc, data_in);
        end else begin
          chk("data_in", 32'(data_in), 32'(exp_q.pop_front()));
        end
        wr_log.push_back(data_in);
        wr_cyc.push_back(cyc);
        n_writes++;
        if (req_last[m_owner]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_beats = 0;
        end else if (m_beats == MAXB) begin
          m_ov = 1'b1;
        end else begin
          m_beats++;
        end
      end else if (m_owner < 0 && req_valid != '0) begin
        for (int k = 0; k < N; k++) begin
          m_j = (m_ptr + k) % N;
          if (req_valid[m_j]) begin
            m_owner = m_j;
            break;
          end
        end
        gnt_log.push_back(m_owner);
        for (int b = 0; b < bq_data[m_owner].size(); b++) begin
          exp_q.push_back(bq_data[m_owner][b]);
          if (bq_last[m_owner][b]) break;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [DW-1:0] dd;
    bit dl;
    @(posedge wclk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && bq_data[i].size() > 0) begin
        dd = bq_data[i].pop_front();
        dl = bq_last[i].pop_front();
        acc_cnt[i]++;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (en[i] && bq_data[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_last[i]           = bq_last[i][0];
        req_data[i*DW +: DW]  = bq_data[i][0];
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'($urandom_range(0, 1));
        req_data[i*DW +: DW]  = DW'($urandom_range(0, 255));
      end
    end
    full = full_drv;
  endtask

  task automatic push_pkt(input int r, input int len, input logic [DW-1:0] base);
    for (int b = 0; b < len; b++) begin
      bq_data[r].push_back(base + DW'(b));
      bq_last[r].push_back(b == len - 1);
    end
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (bq_data[i].size() != 0) return 1'b0;
    return busy === 1'b0;
  endfunction

  task automatic drain(input string name, input int budget);
    int c;
    c = 0;
    while (!all_done() && c < budget) begin
      tick();
      drive();
      c++;
    end
    if (!all_done()) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int gbase, wbase, c0, left, total;
  bit started, fired, hold;

  initial begin
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    drive();
    repeat (3) @(posedge wclk);
    #1;
    wrst = 1'b0;
    drive();
    #3;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_w_en", 32'(w_en), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);

    // Fairness: everyone always valid with 2-beat packets.
    gbase = gnt_log.size();
    wbase = wr_cyc.size();
    for (int r = 0; r < N; r++) begin
      push_pkt(r, 2, DW'(8'h10 * (r + 1)));
      push_pkt(r, 2, DW'(8'h10 * (r + 1) + 8'h08));
    end
    en = '1;
    full_drv = 1'b0;
    drain("fair", 200);
    chk("fair_grants", 32'(gnt_log.size() - gbase), 32'd8);
    for (int k = 0; k < 5; k++) chk("fair_order", 32'(gnt_log[gbase + k]), 32'(k % N));
    chk("fair_writes", 32'(wr_cyc.size() - wbase), 32'd16);
    chk("fair_span", 32'(wr_cyc[wbase + 15] - wr_cyc[wbase]), 32'd22);

    // Single-beat packets from 0 and 3.
    wbase = wr_cyc.size();
    push_pkt(0, 1, 8'h5A);
    push_pkt(3, 1, 8'hC3);
    en = 4'b1001;
    tick();
    c0 = cyc;
    drive();
    drain("single", 50);
    chk("single_writes", 32'(wr_cyc.size() - wbase), 32'd2);
    chk("single_cyc0", 32'(wr_cyc[wbase] - c0), 32'd1);
    chk("single_cyc1", 32'(wr_cyc[wbase + 1] - c0), 32'd3);
    chk("single_rr_ptr", 32'(dut.rr_ptr), 32'd0);

    // Backpressure: full for 2 cycles after the first beat.
    wr_log.delete();
    bq_data[2].push_back(8'hA1); bq_last[2].push_back(1'b0);
    bq_data[2].push_back(8'hA2); bq_last[2].push_back(1'b0);
    bq_data[2].push_back(8'hA3); bq_last[2].push_back(1'b1);
    en = 4'b0100;
    started = 1'b0;
    left = 0;
    for (int c = 0; c < 50 && !all_done(); c++) begin
      tick();
      if (!started && bq_data[2].size() == 2) begin
        started = 1'b1;
        left = 2;
      end
      full_drv = (left > 0);
      if (left > 0) left--;
      drive();
      if (full_drv) begin
        #3;
        chk("bp_w_en_full", 32'(w_en), 32'd0);
        chk("bp_ready_full", 32'(req_ready), 32'd0);
      end
    end
    full_drv = 1'b0;
    chk("bp_done", 32'(all_done()), 32'd1);
    chk("bp_count", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      chk("bp_d0", 32'(wr_log[0]), 32'hA1);
      chk("bp_d1", 32'(wr_log[1]), 32'hA2);
      chk("bp_d2", 32'(wr_log[2]), 32'hA3);
    end

    // Grant hold: owner 1 drops valid for 3 cycles while requester 0 waits.
    wr_log.delete();
    gbase = gnt_log.size();
    push_pkt(1, 3, 8'h60);
    push_pkt(0, 1, 8'h70);
    en = 4'b0010;
    started = 1'b0;
    left = 0;
    for (int c = 0; c < 50 && !all_done(); c++) begin
      tick();
      if (!started && bq_data[1].size() == 2) begin
        started = 1'b1;
        left = 3;
        en[0] = 1'b1;
      end
      hold = (left > 0);
      en[1] = !hold;
      if (left > 0) left--;
      drive();
      if (hold) begin
        #3;
        chk("hold_grant", 32'(grant), 32'h2);
        chk("hold_w_en", 32'(w_en), 32'd0);
      end
    end
    chk("hold_done", 32'(all_done()), 32'd1);
    chk("hold_grants", 32'(gnt_log.size() - gbase), 32'd2);
    if (gnt_log.size() - gbase == 2) begin
      chk("hold_first", 32'(gnt_log[gbase]), 32'd1);
      chk("hold_second", 32'(gnt_log[gbase + 1]), 32'd0);
    end
    chk("hold_count", 32'(wr_log.size()), 32'd4);

    // Randomized traffic with random valid gaps and backpressure.
    wbase = n_writes;
    total = 0;
    for (int p = 0; p < 40; p++) begin
      int r, len;
      r = $urandom_range(0, N - 1);
      len = $urandom_range(1, MAXB);
      for (int b = 0; b < len; b++) begin
        bq_data[r].push_back(DW'($urandom_range(0, 255)));
        bq_last[r].push_back(b == len - 1);
      end
      total += len;
    end
    for (int c = 0; c < 3000 && !all_done(); c++) begin
      tick();
      for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 9) < 7);
      full_drv = ($urandom_range(0, 3) == 0);
      drive();
    end
    en = '1;
    full_drv = 1'b0;
    drain("rand", 500);
    chk("rand_writes", 32'(n_writes - wbase), 32'(total));
    chk("rand_exp_empty", 32'(exp_q.size()), 32'd0);

    // Overrun: 6 beats against a limit of 4.
    wbase = n_writes;
    push_pkt(0, 6, 8'h30);
    en = 4'b0001;
    for (int c = 0; c < 50 && !all_done(); c++) begin
      tick();
      if (n_writes - wbase == 4 && bq_data[0].size() == 2) chk("ovr_after4", 32'(overrun), 32'd0);
      if (n_writes - wbase == 5 && bq_data[0].size() == 1) chk("ovr_after5", 32'(overrun), 32'd1);
      drive();
    end
    chk("ovr_done", 32'(all_done()), 32'd1);
    chk("ovr_writes", 32'(n_writes - wbase), 32'd6);
    repeat (3) begin
      tick();
      drive();
    end
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset during beat 2 of requester 3's packet.
    push_pkt(3, 4, 8'h40);
    en = 4'b1000;
    fired = 1'b0;
    for (int c = 0; c < 50 && !fired; c++) begin
      tick();
      if (bq_data[3].size() == 3) begin
        wrst = 1'b1;
        fired = 1'b1;
      end
      drive();
    end
    chk("rstmid_fired", 32'(fired), 32'd1);
    tick();
    wrst = 1'b0;
    bq_data[3].delete();
    bq_last[3].delete();
    en = '0;
    drive();
    #3;
    chk("rstmid_grant", 32'(grant), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_w_en", 32'(w_en), 32'd0);
    chk("rstmid_overrun", 32'(overrun), 32'd0);
    gbase = gnt_log.size();
    push_pkt(0, 1, 8'h50);
    push_pkt(3, 1, 8'h58);
    en = 4'b1001;
    drain("rstmid", 50);
    chk("rstmid_grants", 32'(gnt_log.size() - gbase), 32'd2);
    if (gnt_log.size() - gbase == 2) chk("rstmid_winner", 32'(gnt_log[gbase]), 32'd0);

    repeat (2) begin
      tick();
      drive();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Shares the single write port of the asynchronous FIFO among `NUM_REQ` producers in the write clock domain. Grants are round-robin at packet granularity: once a requester wins, it keeps the port until its `last` beat is written, so packets never interleave in the FIFO. The block drives the FIFO's `w_en`/`data_in` and honours its `full` flag. It sits between the producer blocks and the FIFO write side.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 8: FIFO data width.
- `MAX_BEATS`, default 64: packet length limit used for overrun detection.
- `wclk`  in  1  write-domain clock, the only clock.
- `wrst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_last`  in  NUM_REQ  per-requester last beat of packet.
- `req_data`  in  NUM_REQ*DATA_WIDTH  flattened data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  beat accepted when valid & ready.
- `full`  in  1  FIFO full flag, already synchronized.
- `w_en`  out  1  FIFO write enable.
- `data_in`  out  DATA_WIDTH  FIFO write data.
- `grant`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `busy`  out  1  a packet is in progress.
- `overrun`  out  1  sticky; set when a packet exceeds MAX_BEATS beats.

## Operation
- The FSM has two states, IDLE and BURST. The owner index is `$clog2(NUM_REQ)` bits wide.
- **IDLE:**
  - If any `req_valid` is set, pick the first valid requester searching from `rr_ptr` upward with wrap.
  - Register the winner as owner and enter BURST.
  - `req_ready`, `w_en` and `grant` are 0.
- **BURST:**
  - `grant[owner]` is 1.
  - `req_ready[owner] = !full`; all other ready bits are 0.
  - `w_en = req_valid[owner] & !full`, and `data_in` is the owner's data slice.
  - On an accepted beat (`w_en` = 1), `beat_cnt` increments.
  - On an accepted beat with `req_last[owner]` set:
    - return to IDLE;
    - set `rr_ptr = owner+1`, wrapping to 0 after `NUM_REQ-1`;
    - clear `beat_cnt`.
- **Owner drops `req_valid` mid-packet:** the grant is held, no write occurs, and the FSM stays in BURST.
- **`full` asserted:** `w_en` and `req_ready` are 0 and data is held by the requester. `w_en` is never asserted while `full` = 1.
- **Overrun:** if `beat_cnt` reaches `MAX_BEATS` and another beat is accepted without `last`, `overrun` is set. It stays set until reset. The grant continues; `beat_cnt` saturates.
- **Single-beat packet** (`valid` & `last` on the first beat): one write, then IDLE.
- **Non-owners:** `valid`/`last` from non-owners are ignored while in BURST.
- **Reset** (`wrst` = 1 at a `wclk` edge), including mid-packet:
  - state IDLE, `rr_ptr` 0, owner 0, `beat_cnt` 0, `overrun` 0;
  - all outputs 0: `grant`, `busy`, `w_en`, `req_ready`, `overrun`; `data_in` is 0 because its select is idle.
  - The interrupted packet is abandoned. The FIFO already holds a partial packet; its recovery is system-level.

## Timing
- Arbitration latency is 1 cycle. A `req_valid` sampled in IDLE at edge N gives `grant` and `busy` high after edge N, and the first write can occur in cycle N+1.
- Throughput is 1 beat/cycle inside a packet when `full` = 0.
- There is one IDLE bubble cycle between packets.
- `w_en`, `req_ready` and `data_in` are combinational from registered state plus `full`/`req_valid`.
- `grant`, `busy` and `overrun` are registered.
- `busy` = (state == BURST).

## Structure
- Shared package `fifo_ctrl_pkg` holds:
  - state encodings `ST_IDLE` = 0 and `ST_BURST` = 1;
  - a `clog2`-style width helper if the tool flow requires one.
- Sub-module `rr_picker` is purely combinational. Inputs: `req` and `ptr`. Outputs: `winner` index and `any`. It is parameterized by `NUM_REQ` and reusable by a future read-side scheduler.
- The FSM, `beat_cnt`, `rr_ptr` and output muxing live in `fifo_write_arbiter`.

## Test plan
- **Fairness:** all 4 requesters hold `valid` continuously with 2-beat packets → grant order 0,1,2,3,0; 8 writes per rotation, one idle cycle between packets.
- **Backpressure:** requester 2 sends 3 beats `0xA1,0xA2,0xA3`; `full` is high for 2 cycles after the first beat → `w_en` is 0 during `full`; the FIFO receives exactly `A1,A2,A3` in order.
- **Grant hold:** requester 1 owns the port and drops `valid` for 3 cycles mid-packet while requester 0 is valid → `grant` stays `4'b0010` and no writes occur until requester 1 resumes and sends `last`.
- **Single-beat packets:** requesters 0 and 3 each send one beat with `last` → writes occur in cycles 1 and 3 after the request, and `rr_ptr` ends at 0.
- **Overrun:** `MAX_BEATS` = 4; requester 0 sends 6 beats, `last` on the 6th → `overrun` goes high after the 5th beat and stays high; all 6 beats are written.
- **Reset mid-packet:** `wrst` is pulsed during beat 2 of requester 3's packet → the next cycle has `grant` = 0, `busy` = 0, `w_en` = 0; with requesters 0 and 3 valid afterwards, requester 0 wins.
